// File: rtl/regfile_wb_queue.sv
// Write-back queue: sole writer of the register-file port; MEM/ALU results drained one per cycle in order.
// Latency: a handshake in cycle N drives WE3/A3/WD3 in cycle N+2. Backpressure: readies follow start-of-cycle occupancy, and MEM takes the last slot.
// Optional REGFILE_WB_BYPASS_EN builds the pending-write lookup on ra1/ra2; otherwise hit/fwd are tied to 0.
module regfile_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    output logic [4:0]  A3,
    output logic [31:0] WD3,
    output logic        WE3,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic        hit1,
    output logic        hit2,
    output logic [31:0] fwd1,
    output logic [31:0] fwd2,
    output logic        busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    logic [4:0]    addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] alu_slot;
    logic [CW-1:0] count;
    logic          mem_push;
    logic          alu_push;
    logic          pop;

    // Readies see only start-of-cycle occupancy; a same-cycle pop is not credited.
    assign mem_ready = (count < FULL);
    assign alu_ready = (count < LAST) || ((count == LAST) && !mem_valid);

    // Address-0 results complete the handshake but never occupy a slot.
    assign mem_push = mem_valid && mem_ready && (mem_addr != 5'd0);
    assign alu_push = alu_valid && alu_ready && (alu_addr != 5'd0);
    assign pop      = (count != '0);
    assign alu_slot = wr_ptr + PW'(mem_push);
    assign busy     = pop || WE3;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            A3     <= '0;
            WD3    <= '0;
            WE3    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PW'(mem_push) + PW'(alu_push);
            count  <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
            WE3    <= pop;
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                A3     <= addr_q[rd_ptr];
                WD3    <= data_q[rd_ptr];
            end
        end
    end

    // Storage needs no reset: only slots below count are ever read.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            addr_q[wr_ptr] <= mem_addr;
            data_q[wr_ptr] <= mem_data;
        end
        if (alu_push) begin
            addr_q[alu_slot] <= alu_addr;
            data_q[alu_slot] <= alu_data;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Oldest-to-newest scan so later matches overwrite earlier ones; output register is oldest of all.
    function automatic logic [32:0] lookup(input logic [4:0] ra);
        logic [32:0]   r;
        logic [PW-1:0] idx;
        r = '0;
        if (ra != 5'd0) begin
            if (WE3 && (A3 == ra)) r = {1'b1, WD3};
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PW'(i);
                if ((CW'(i) < count) && (addr_q[idx] == ra)) r = {1'b1, data_q[idx]};
            end
        end
        return r;
    endfunction

    always_comb begin
        {hit1, fwd1} = lookup(ra1);
        {hit2, fwd2} = lookup(ra2);
    end
`else
    logic unused_ra;
    assign unused_ra = ^{ra1, ra2};
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
    assign fwd1 = '0;
    assign fwd2 = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue (DEPTH=4); bypass expectations follow REGFILE_WB_BYPASS_EN.
module tb_regfile_wb_queue;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, alu_valid;
    logic [4:0]  mem_addr, alu_addr;
    logic [31:0] mem_data, alu_data;
    logic        mem_ready, alu_ready;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        WE3;
    logic [4:0]  ra1, ra2;
    logic        hit1, hit2;
    logic [31:0] fwd1, fwd2;
    logic        busy;

    int checks = 0;
    int errors = 0;

    regfile_wb_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .A3(A3), .WD3(WD3), .WE3(WE3),
        .ra1(ra1), .ra2(ra2), .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    logic [36:0] exp_q[$];
    int          cnt, total, ms, as, mi, ai;
    bit          saw3, mem_acc, alu_acc;

    initial begin
        rst = 1'b1;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        ra1 = '0; ra2 = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_A3", A3, 0);
        check("rst_WD3", WD3, 0);
        check("rst_WE3", WE3, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_ready", mem_ready, 1);
        check("rst_alu_ready", alu_ready, 1);
        check("rst_hit1", hit1, 0);
        check("rst_hit2", hit2, 0);

        // Single ALU write: cycle 1 handshake, write visible in cycle 3 only.
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234_5678;
        #1;
        check("c1_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        check("c2_WE3", WE3, 0);
        check("c2_busy", busy, 1);
        tick();
        check("c3_WE3", WE3, 1);
        check("c3_A3", A3, 5);
        check("c3_WD3", WD3, 32'h1234_5678);
        tick();
        check("c4_WE3", WE3, 0);
        check("c4_busy", busy, 0);

        // Both producers to r3: MEM older, ALU newer.
        mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'hA;
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hB;
        #1;
        check("dual_mem_ready", mem_ready, 1);
        check("dual_alu_ready", alu_ready, 1);
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0; ra1 = 5'd3; ra2 = 5'd4;
        #1;
        check("dual_q_hit1", hit1, BYP);
        check("dual_q_fwd1", fwd1, BYP ? 32'hB : 32'h0);
        check("dual_q_hit2", hit2, 0);
        tick();
        check("dual_w1_WE3", WE3, 1);
        check("dual_w1_WD3", WD3, 32'hA);
        check("dual_w1_hit1", hit1, BYP);
        check("dual_w1_fwd1", fwd1, BYP ? 32'hB : 32'h0);
        tick();
        check("dual_w2_WE3", WE3, 1);
        check("dual_w2_A3", A3, 3);
        check("dual_w2_WD3", WD3, 32'hB);
        check("dual_w2_fwd1", fwd1, BYP ? 32'hB : 32'h0);
        tick();
        check("dual_end_WE3", WE3, 0);
        check("dual_end_hit1", hit1, 0);
        check("dual_end_fwd1", fwd1, 0);
        ra1 = '0; ra2 = '0;

        // Continuous producers: model occupancy, check readies and write order.
        cnt = 0; total = 0; ms = 0; as = 0; saw3 = 1'b0;
        mem_acc = 1'b0; alu_acc = 1'b0;
        for (int cyc = 0; cyc < 200 && (total < 20 || exp_q.size() > 0); cyc++) begin
            if (mem_acc) ms++;
            if (alu_acc) as++;
            if (WE3) begin
                if (exp_q.size() == 0) check("stream_extra_write", {A3, WD3}, 0);
                else check("stream_order", {A3, WD3}, exp_q.pop_front());
            end
            mi = ms % 15;
            ai = as % 15;
            mem_addr = 5'(1 + mi);  mem_data = 32'h1000_0000 + 32'(ms);
            alu_addr = 5'(16 + ai); alu_data = 32'h2000_0000 + 32'(as);
            mem_valid = (total < 20);
            alu_valid = (total < 20);
            #1;
            check("stream_mem_ready", mem_ready, (cnt < 4));
            check("stream_alu_ready", alu_ready, (cnt <= 2) || (cnt == 3 && !mem_valid));
            mem_acc = mem_valid && mem_ready;
            alu_acc = alu_valid && alu_ready;
            if (cnt == 3 && mem_valid && alu_valid && mem_acc && !alu_acc) saw3 = 1'b1;
            if (mem_acc) begin exp_q.push_back({mem_addr, mem_data}); total++; end
            if (alu_acc) begin exp_q.push_back({alu_addr, alu_data}); total++; end
            cnt = cnt + int'(mem_acc) + int'(alu_acc) - int'(cnt != 0);
            tick();
        end
        mem_valid = 1'b0; alu_valid = 1'b0;
        check("stream_total", total >= 20, 1);
        check("stream_drained", exp_q.size(), 0);
        check("stream_mem_only_at_3", saw3, 1);
        check("stream_idle_WE3", WE3, 0);

        // Address 0: handshake completes, nothing written.
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFF_FFFF; ra1 = 5'd0;
        #1;
        check("r0_alu_ready", alu_ready, 1);
        check("r0_hit1", hit1, 0);
        tick();
        alu_valid = 1'b0;
        check("r0_busy", busy, 0);
        tick();
        check("r0_WE3_a", WE3, 0);
        check("r0_fwd1", fwd1, 0);
        tick();
        check("r0_WE3_b", WE3, 0);

        // Three entries queued, then a one-cycle reset discards them.
        mem_valid = 1'b1; mem_addr = 5'd9;  mem_data = 32'h9;
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'h10;
        tick();
        mem_addr = 5'd11; mem_data = 32'h11;
        alu_addr = 5'd12; alu_data = 32'h12;
        #1;
        check("pre_rst_alu_ready", alu_ready, 1);
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_WE3", WE3, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_mem_ready", mem_ready, 1);
        check("mid_rst_alu_ready", alu_ready, 1);
        tick();
        check("post_rst_WE3_a", WE3, 0);
        tick();
        check("post_rst_WE3_b", WE3, 0);

        // Pending write to r7: lookup depends on build, write always happens.
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77; ra1 = 5'd7;
        tick();
        alu_valid = 1'b0;
        check("r7_hit1", hit1, BYP);
        check("r7_fwd1", fwd1, BYP ? 32'h77 : 32'h0);
        tick();
        check("r7_WE3", WE3, 1);
        check("r7_A3", A3, 7);
        check("r7_WD3", WD3, 32'h77);
        tick();
        check("r7_done_WE3", WE3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
